// File: rtl/wide_add_pkg.sv
// Shared types and defaults for the sliced wide adder.
// Optional WIDE_ADD_OVF_EN adds a signed-overflow flag.
package wide_add_pkg;

  localparam int W_DEF     = 128;
  localparam int CHUNK_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_e;

  // A single-slice build still needs a 1-bit index.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wide_add_sequencer_if.sv
// Operand/result handshake bundle for wide_add_sequencer.
// Carries ovf only when WIDE_ADD_OVF_EN is defined.
interface wide_add_sequencer_if
  import wide_add_pkg::*;
#(
  parameter int W = W_DEF
);

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;
`ifdef WIDE_ADD_OVF_EN
  logic         ovf;
`endif

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout,
`ifdef WIDE_ADD_OVF_EN
    input  ovf,
`endif
    input  busy
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout,
`ifdef WIDE_ADD_OVF_EN
    output ovf,
`endif
    output busy
  );

endinterface

// File: rtl/ripple_slice_adder.sv
// CHUNK-bit ripple-carry adder built from full_adder cells.
// One instance is time-shared across all slices of the wide add.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;

  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);

endmodule

module ripple_slice_adder #(
  parameter int CHUNK = 32
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout
);

  logic [CHUNK:0] c;

  assign c[0] = cin;
  assign cout = c[CHUNK];

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    full_adder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

endmodule

// File: rtl/wide_add_sequencer.sv
// Multi-cycle W-bit adder: one CHUNK slice per cycle, LSB first.
// Define WIDE_ADD_OVF_EN to add the signed-overflow output ovf.
module wide_add_sequencer
  import wide_add_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int CHUNK = CHUNK_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  wide_add_sequencer_if.slave  bus
);

  localparam int N  = W / CHUNK;
  localparam int IW = idx_w(N);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef logic [N-1:0][CHUNK-1:0] vec_t;

  state_e        state_q, state_d;
  vec_t          a_q, a_d;
  vec_t          b_q, b_d;
  vec_t          sum_q, sum_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          carry_q, carry_d;
  logic          cout_q, cout_d;
`ifdef WIDE_ADD_OVF_EN
  logic          ovf_q, ovf_d;
`endif

  logic [CHUNK-1:0] sl_s;
  logic             sl_co;
  logic             last;

  ripple_slice_adder #(
    .CHUNK (CHUNK)
  ) u_slice (
    .a    (a_q[idx_q]),
    .b    (b_q[idx_q]),
    .cin  (carry_q),
    .s    (sl_s),
    .cout (sl_co)
  );

  assign last = (idx_q == LAST);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
`ifdef WIDE_ADD_OVF_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = bus.cin;
          idx_d   = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        sum_d[idx_q] = sl_s;
        carry_d      = sl_co;
        if (last) begin
          cout_d  = sl_co;
          state_d = DONE;
`ifdef WIDE_ADD_OVF_EN
          // MSB carry-in equals a^b^s at the top bit.
          ovf_d = a_q[N-1][CHUNK-1]
                ^ b_q[N-1][CHUNK-1]
                ^ sl_s[CHUNK-1]
                ^ sl_co;
`endif
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
`ifdef WIDE_ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
`ifdef WIDE_ADD_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
`ifdef WIDE_ADD_OVF_EN
  assign bus.ovf       = ovf_q;
`endif

endmodule

// File: doc/wide_add_sequencer.md
WIDE_ADD_SEQUENCER -- requirements
Module: wide_add_sequencer

Interface
REQ-001 The block SHALL take parameter W, default 128, as the total operand width in bits.
REQ-002 The block SHALL take parameter CHUNK, default 32, as the per-cycle adder slice width; W SHALL be an integer multiple of CHUNK.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  operand set offered.
REQ-007 in_ready  output  1  block can accept operands.
REQ-008 a, b  input  W  addends.
REQ-009 cin  input  1  carry-in.
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 sum  output  W  result.
REQ-013 cout  output  1  final carry-out.
REQ-014 busy  output  1  high in ADD or DONE.

Function
REQ-015 The FSM SHALL have states IDLE, ADD and DONE, with N = W/CHUNK slices.
REQ-016 IDLE: in_ready=1; in_valid=1 SHALL register a, b and cin, clear slice index idx to 0, and go to ADD.
REQ-017 ADD: each cycle SHALL add slice idx of a and b with the carry register, write sum[idx*CHUNK +: CHUNK], store the slice carry-out, and increment idx.
REQ-018 ADD SHALL go to DONE after slice N-1, so out_valid rises exactly N cycles after the accept edge (4 with defaults).
REQ-019 DONE: out_valid=1, with sum and cout stable; out_ready=1 SHALL return the FSM to IDLE on that edge.
REQ-020 in_ready SHALL be 0 in ADD and DONE, and in_valid there SHALL be ignored, with no back-to-back accept in the DONE handoff cycle.
REQ-021 A change on a, b or cin after the accept SHALL NOT affect the result.
REQ-022 out_ready while not in DONE SHALL have no effect.
REQ-023 idx SHALL be $clog2(N) bits wide and SHALL NOT wrap within a transaction; N=1 SHALL take one ADD cycle.
REQ-024 sum and cout SHALL equal (a+b+cin) mod 2^(W+1), split as cout:sum.

Reset
REQ-025 rst_n low SHALL immediately force IDLE, idx=0, carry=0, sum=0, cout=0, out_valid=0 and busy=0, and make in_ready=1.
REQ-026 Reset mid-ADD or mid-DONE SHALL discard the transaction, and no out_valid SHALL follow.

Configuration
REQ-027 With WIDE_ADD_OVF_EN defined, the block SHALL add a 1-bit output ovf: two's-complement signed overflow (carry into MSB XOR cout), valid with out_valid and reset to 0.
REQ-028 Without WIDE_ADD_OVF_EN, the ovf port and its logic SHALL NOT exist, and all other behaviour SHALL be identical.

Structure
REQ-029 Package wide_add_pkg SHALL hold the state enum typedef (IDLE/ADD/DONE) and the default W and CHUNK constants.
REQ-030 The slice adder SHALL be a sub-module ripple_slice_adder (CHUNK-bit ripple of full_adder cells, with cin/cout ports), instantiated once and reused each ADD cycle.

Verification
REQ-031 Test a=0xFFFF_FFFF (low word only), b=1, cin=0 -> sum=0x1_0000_0000, cout=0, out_valid at accept+4.
REQ-032 Test a=all-ones(128), b=0, cin=1 -> sum=0, cout=1, with the carry rippling across all 4 slices.
REQ-033 Test a result held in DONE with out_ready=0 for 10 cycles -> sum stable, in_ready=0, in_valid pulses ignored; then out_ready=1 -> IDLE the next cycle.
REQ-034 Test rst_n low at ADD cycle 2 -> outputs zero immediately; a new transaction a=5, b=7 -> sum=12.
REQ-035 Test a, b changed every cycle during ADD -> result matches the values captured at accept.
REQ-036 With WIDE_ADD_OVF_EN, test a=0x7FFF...F, b=1 -> ovf=1; a=1, b=1 -> ovf=0.
